alu_instr_issuer: RTL and testbench

//  Instruction-driven front end for RegFile_Alu; replaces manual switch/button field loading.

---
 rtl/alu_issue_pkg.sv | 44 ++++
 rtl/alu_instr_issuer_if.sv | 29 ++
 rtl/sync_fifo.sv | 78 +++++++
 rtl/alu_instr_issuer.sv | 176 +++++++++++++++++
 tb/tb_alu_instr_issuer.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU instruction issuer.
//   state_t         issuer FSM states
//   field positions bit layout of the 16-bit instruction word
//                   [15] imm_s, [14:10] opcode, [9:6] rdest, [5:2] rsrc, [1:0] reserved
//   RST_OPCODE_DEF  default opcode that pulses the ALU reset instead of an operation
//   decode_instr    splits the instruction header (bits [15:2]) into its fields
package alu_issue_pkg;

  localparam int unsigned INSTR_W   = 16;
  localparam int unsigned IMM_S_BIT = 15;
  localparam int unsigned OPC_MSB   = 14;
  localparam int unsigned OPC_LSB   = 10;
  localparam int unsigned RDEST_MSB = 9;
  localparam int unsigned RDEST_LSB = 6;
  localparam int unsigned RSRC_MSB  = 5;
  localparam int unsigned RSRC_LSB  = 2;

  localparam logic [4:0] RST_OPCODE_DEF = 5'h1F;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_IMM,
    ISSUE,
    RESULT
  } state_t;

  typedef struct packed {
    logic       imm_s;
    logic [4:0] opcode;
    logic [3:0] rdest;
    logic [3:0] rsrc;
  } instr_fields_t;

  // Takes only the header bits; the two reserved bits never reach decode.
  function automatic instr_fields_t decode_instr(input logic [INSTR_W-1:RSRC_LSB] hdr);
    instr_fields_t f;
    f.imm_s  = hdr[IMM_S_BIT];
    f.opcode = hdr[OPC_MSB:OPC_LSB];
    f.rdest  = hdr[RDEST_MSB:RDEST_LSB];
    f.rsrc   = hdr[RSRC_MSB:RSRC_LSB];
    return f;
  endfunction

endpackage

// File: rtl/alu_instr_issuer_if.sv
// alu_instr_issuer_if: host-facing handshake bundle of the ALU instruction issuer.
//   instr_data/instr_valid/instr_ready       instruction word channel (host -> issuer)
//   result_data/result_flags/result_valid/
//   result_ready                             result channel (issuer -> host)
//   modport master : host / sequencer side
//   modport slave  : issuer side
interface alu_instr_issuer_if;
  import alu_issue_pkg::*;

  logic [INSTR_W-1:0] instr_data;
  logic               instr_valid;
  logic               instr_ready;

  logic [INSTR_W-1:0] result_data;
  logic [4:0]         result_flags;
  logic               result_valid;
  logic               result_ready;

  modport master (
    output instr_data, instr_valid, result_ready,
    input  instr_ready, result_data, result_flags, result_valid
  );

  modport slave (
    input  instr_data, instr_valid, result_ready,
    output instr_ready, result_data, result_flags, result_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count-based full/empty and a registered head word.
//   clk       in  clock, posedge
//   rst       in  synchronous active-high reset (empties the FIFO)
//   i_push    in  write request (ignored while full)
//   i_wr_data in  WIDTH write data
//   i_pop     in  read request (ignored while empty)
//   o_rd_data out WIDTH head-of-FIFO word, valid whenever !o_empty
//   o_full    out count == DEPTH
//   o_empty   out count == 0
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_rd_data;

  logic             w_push;
  logic             w_pop;
  logic [AW-1:0]    w_rd_ptr_nxt;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
  assign o_rd_data    = r_rd_data;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // The head register tracks mem[next read pointer]; when that slot is
      // being written this same edge, bypass the incoming word so the head
      // is valid the cycle after a push into an empty (or draining) FIFO.
      if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
        r_rd_data <= i_wr_data;
      end else begin
        r_rd_data <= r_mem[w_rd_ptr_nxt];
      end
    end
  end

endmodule

// File: rtl/alu_instr_issuer.sv
// alu_instr_issuer: instruction-driven front end for RegFile_Alu.
// Buffers 16-bit instruction words in a FIFO, decodes each into RegFile_Alu
// control fields, pulses alu_en (or alu_rst for RST_OPCODE) for one clock and
// returns the captured ALU output/flags over a valid/ready result channel.
//   clk          in   clock, posedge
//   Rst          in   synchronous active-high reset
//   bus          slave instruction channel (instr_*) and result channel (result_*)
//   alu_rdest    out  4  RdestRegLoc
//   alu_rsrc     out  4  RsrcRegLoc
//   alu_opcode   out  5  OpCode
//   alu_imm      out  16 Imm (held across non-immediate operations)
//   alu_imm_s    out  1  Imm_s
//   alu_en       out  1  one-cycle pulse per operation
//   alu_rst      out  1  one-cycle pulse for RST_OPCODE
//   alu_result   in   16 AluOutput
//   alu_flags    in   5  Flags
//   busy         out  1  FSM not idle or FIFO holds words
module alu_instr_issuer
  import alu_issue_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [4:0]  RST_OPCODE = RST_OPCODE_DEF
) (
  input  logic               clk,
  input  logic               Rst,
  alu_instr_issuer_if.slave  bus,
  output logic [3:0]         alu_rdest,
  output logic [3:0]         alu_rsrc,
  output logic [4:0]         alu_opcode,
  output logic [INSTR_W-1:0] alu_imm,
  output logic               alu_imm_s,
  output logic               alu_en,
  output logic               alu_rst,
  input  logic [INSTR_W-1:0] alu_result,
  input  logic [4:0]         alu_flags,
  output logic               busy
);

  state_t              r_state;
  state_t              w_state_nxt;

  logic [3:0]          r_rdest;
  logic [3:0]          r_rsrc;
  logic [4:0]          r_opcode;
  logic [INSTR_W-1:0]  r_imm;
  logic                r_imm_s;
  logic [INSTR_W-1:0]  r_result_data;
  logic [4:0]          r_result_flags;
  logic                r_result_valid;

  logic [INSTR_W-1:0]  w_fifo_data;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_pop;
  instr_fields_t       w_dec;

  logic                w_latch_instr;
  logic                w_latch_imm;
  logic                w_capture;
  logic                w_clear_result;
  logic                w_alu_en;
  logic                w_alu_rst;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (Rst),
    .i_push    (bus.instr_valid),
    .i_wr_data (bus.instr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );

  assign w_dec = decode_instr(w_fifo_data[INSTR_W-1:RSRC_LSB]);

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pop          = 1'b0;
    w_latch_instr  = 1'b0;
    w_latch_imm    = 1'b0;
    w_capture      = 1'b0;
    w_clear_result = 1'b0;
    w_alu_en       = 1'b0;
    w_alu_rst      = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_latch_instr = 1'b1;
          w_state_nxt   = w_dec.imm_s ? FETCH_IMM : ISSUE;
        end
      end
      FETCH_IMM: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_latch_imm = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (r_opcode == RST_OPCODE) begin
          w_alu_rst   = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_alu_en    = 1'b1;
          w_capture   = 1'b1;
          w_state_nxt = RESULT;
        end
      end
      RESULT: begin
        if (bus.result_ready) begin
          w_clear_result = 1'b1;
          w_state_nxt    = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      r_rdest        <= '0;
      r_rsrc         <= '0;
      r_opcode       <= '0;
      r_imm          <= '0;
      r_imm_s        <= 1'b0;
      r_result_data  <= '0;
      r_result_flags <= '0;
      r_result_valid <= 1'b0;
    end else begin
      if (w_latch_instr) begin
        r_rdest  <= w_dec.rdest;
        r_rsrc   <= w_dec.rsrc;
        r_opcode <= w_dec.opcode;
        r_imm_s  <= w_dec.imm_s;
      end
      if (w_latch_imm) begin
        r_imm <= w_fifo_data;
      end
      if (w_capture) begin
        r_result_data  <= alu_result;
        r_result_flags <= alu_flags;
        r_result_valid <= 1'b1;
      end else if (w_clear_result) begin
        r_result_valid <= 1'b0;
      end
    end
  end

  assign bus.instr_ready  = !w_fifo_full;
  assign bus.result_data  = r_result_data;
  assign bus.result_flags = r_result_flags;
  assign bus.result_valid = r_result_valid;

  assign alu_rdest  = r_rdest;
  assign alu_rsrc   = r_rsrc;
  assign alu_opcode = r_opcode;
  assign alu_imm    = r_imm;
  assign alu_imm_s  = r_imm_s;
  assign alu_en     = w_alu_en;
  assign alu_rst    = w_alu_rst;
  assign busy       = (r_state != IDLE) || !w_fifo_empty;

endmodule

// File: tb/tb_alu_instr_issuer.sv
// tb_alu_instr_issuer: directed self-checking bench for alu_instr_issuer.
// Inputs are driven and outputs sampled on the falling clock edge; the ALU is
// a combinational stub that returns 0xBEEF/0x03 only while alu_en is high.
module tb_alu_instr_issuer;

  logic        clk = 1'b0;
  logic        Rst;
  logic [3:0]  alu_rdest;
  logic [3:0]  alu_rsrc;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_imm;
  logic        alu_imm_s;
  logic        alu_en;
  logic        alu_rst;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic        busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned en_cnt = 0;
  int unsigned rst_cnt = 0;
  int unsigned res_hs = 0;
  logic [4:0]  q_ops[$];

  alu_instr_issuer_if bus ();

  alu_instr_issuer #(
    .FIFO_DEPTH (4),
    .RST_OPCODE (5'h1F)
  ) dut (
    .clk        (clk),
    .Rst        (Rst),
    .bus        (bus),
    .alu_rdest  (alu_rdest),
    .alu_rsrc   (alu_rsrc),
    .alu_opcode (alu_opcode),
    .alu_imm    (alu_imm),
    .alu_imm_s  (alu_imm_s),
    .alu_en     (alu_en),
    .alu_rst    (alu_rst),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign alu_result = alu_en ? 16'hBEEF : 16'hDEAD;
  assign alu_flags  = alu_en ? 5'h03 : 5'h1C;

  always @(posedge clk) begin
    if (alu_en === 1'b1) begin
      en_cnt++;
      q_ops.push_back(alu_opcode);
    end
    if (alu_rst === 1'b1) rst_cnt++;
    if (bus.result_valid === 1'b1 && bus.result_ready === 1'b1) res_hs++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Single non-immediate op 0x14DC: rdest=3 rsrc=7 opcode=5, starting from IDLE.
  task automatic run_basic(input string t);
    bus.instr_data  = 16'h14DC;
    bus.instr_valid = 1'b1;
    check({t, ".ready"}, bus.instr_ready, 1);
    tick();
    bus.instr_valid = 1'b0;
    check({t, ".en_e1"}, alu_en, 0);
    check({t, ".busy"}, busy, 1);
    tick();
    check({t, ".en_issue"}, alu_en, 1);
    check({t, ".rdest"}, alu_rdest, 3);
    check({t, ".rsrc"}, alu_rsrc, 7);
    check({t, ".opcode"}, alu_opcode, 5);
    check({t, ".imm_s"}, alu_imm_s, 0);
    check({t, ".rv_issue"}, bus.result_valid, 0);
    tick();
    check({t, ".en_after"}, alu_en, 0);
    check({t, ".rv"}, bus.result_valid, 1);
    check({t, ".rdata"}, bus.result_data, 16'hBEEF);
    check({t, ".rflags"}, bus.result_flags, 5'h03);
    tick();
    check({t, ".rv_held"}, bus.result_valid, 1);
    check({t, ".rdata_held"}, bus.result_data, 16'hBEEF);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check({t, ".rv_clr"}, bus.result_valid, 0);
    check({t, ".idle"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [15:0] t4w [6];
    int unsigned en0;
    int unsigned rst0;
    int unsigned hs0;
    int unsigned w;

    t4w = '{16'h0404, 16'h0808, 16'h0C0C, 16'h1010, 16'h1414, 16'h1818};
    Rst              = 1'b1;
    bus.instr_data   = '0;
    bus.instr_valid  = 1'b0;
    bus.result_ready = 1'b0;

    // Test 1: reset state
    repeat (3) tick();
    check("t1.rdest", alu_rdest, 0);
    check("t1.rsrc", alu_rsrc, 0);
    check("t1.opcode", alu_opcode, 0);
    check("t1.imm", alu_imm, 0);
    check("t1.imm_s", alu_imm_s, 0);
    check("t1.en", alu_en, 0);
    check("t1.rst", alu_rst, 0);
    check("t1.rdata", bus.result_data, 0);
    check("t1.rflags", bus.result_flags, 0);
    check("t1.rv", bus.result_valid, 0);
    check("t1.iready", bus.instr_ready, 1);
    check("t1.busy", busy, 0);
    Rst = 1'b0;
    tick();

    // Test 2: basic op
    run_basic("t2");

    // Test 3: immediate op with a late immediate word
    bus.instr_data  = 16'h8480;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check("t3.en_n1", alu_en, 0);
    tick();
    check("t3.en_stall1", alu_en, 0);
    check("t3.imm_s_latched", alu_imm_s, 1);
    check("t3.busy", busy, 1);
    tick();
    check("t3.en_stall2", alu_en, 0);
    bus.instr_data  = 16'h1234;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check("t3.en_stall3", alu_en, 0);
    tick();
    check("t3.en_issue", alu_en, 1);
    check("t3.opcode", alu_opcode, 1);
    check("t3.rdest", alu_rdest, 2);
    check("t3.rsrc", alu_rsrc, 0);
    check("t3.imm_s", alu_imm_s, 1);
    check("t3.imm", alu_imm, 16'h1234);
    tick();
    check("t3.rv", bus.result_valid, 1);
    bus.result_ready = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    check("t3.rv_clr", bus.result_valid, 0);
    check("t3.idle", busy, 0);

    // Test 4: backpressure fills the FIFO
    q_ops.delete();
    en0 = en_cnt;
    hs0 = res_hs;
    for (int i = 0; i < 5; i++) begin
      bus.instr_data  = t4w[i];
      bus.instr_valid = 1'b1;
      check($sformatf("t4.acc%0d", i), bus.instr_ready, 1);
      tick();
    end
    bus.instr_data  = t4w[5];
    bus.instr_valid = 1'b1;
    check("t4.full", bus.instr_ready, 0);
    tick();
    check("t4.still_full", bus.instr_ready, 0);
    check("t4.rv_pending", bus.result_valid, 1);
    bus.result_ready = 1'b1;
    w = 0;
    while (!bus.instr_ready && w < 10) begin
      tick();
      w++;
    end
    check("t4.slot_freed", bus.instr_ready, 1);
    check("t4.free_delay", w, 2);
    tick();
    bus.instr_valid = 1'b0;
    w = 0;
    while (busy && w < 100) begin
      tick();
      w++;
    end
    check("t4.drained", busy, 0);
    bus.result_ready = 1'b0;
    check("t4.en_count", en_cnt - en0, 6);
    check("t4.results", res_hs - hs0, 6);
    check("t4.nops", q_ops.size(), 6);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] wd;
      wd = t4w[i];
      if (i < q_ops.size()) check($sformatf("t4.order%0d", i), q_ops[i], wd[14:10]);
    end

    // Test 5: reset opcode
    en0  = en_cnt;
    rst0 = rst_cnt;
    hs0  = res_hs;
    bus.instr_data  = 16'h7C00;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    check("t5.rst_early", alu_rst, 0);
    tick();
    check("t5.rst_pulse", alu_rst, 1);
    check("t5.en", alu_en, 0);
    check("t5.opcode", alu_opcode, 5'h1F);
    tick();
    check("t5.rst_done", alu_rst, 0);
    check("t5.rv", bus.result_valid, 0);
    check("t5.idle", busy, 0);
    check("t5.rdata_kept", bus.result_data, 16'hBEEF);
    repeat (2) tick();
    check("t5.rv_later", bus.result_valid, 0);
    check("t5.rst_count", rst_cnt - rst0, 1);
    check("t5.en_count", en_cnt - en0, 0);

    // Test 6: reset while waiting for an immediate
    rst0 = rst_cnt;
    bus.instr_data  = 16'h8480;
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    check("t6.imm_s", alu_imm_s, 1);
    check("t6.opcode", alu_opcode, 1);
    check("t6.busy", busy, 1);
    check("t6.en", alu_en, 0);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check("t6.opcode_rst", alu_opcode, 0);
    check("t6.imm_rst", alu_imm, 0);
    check("t6.busy_rst", busy, 0);
    check("t6.iready_rst", bus.instr_ready, 1);
    check("t6.rdata_rst", bus.result_data, 0);
    run_basic("t6");
    check("t6.no_alu_rst", rst_cnt - rst0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
